univ_shift_reg_p: RTL and testbench
===================================

# univ_shift_reg_p

Parametrised universal shift register: WIDTH-bit, 8 operating modes, serial inputs at both ends, and a burst engine that runs a shift/rotate a programmed number of times and signals completion. Successor to the fixed 4-bit, 4-mode universal register; mode codes 000–011 keep their existing meaning. Used as a generic shift/serialiser stage in the sequential library.

## Interface
- WIDTH, 8, register width (≥2)
- CNT_W, 4, width of burst step count
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high; clears all state
- mode  in  3  operation select (encoding below)
- parallel_in  in  WIDTH  load data
- serial_in_l  in  1  bit entering LSB on SHL
- serial_in_r  in  1  bit entering MSB on SHR
- start  in  1  request burst of `count` steps
- count  in  CNT_W  burst length, 0..2^CNT_W−1
- parallel_out  out  WIDTH  register contents
- serial_out_msb  out  1  combinational parallel_out[WIDTH-1]
- serial_out_lsb  out  1  combinational parallel_out[0]
- busy  out  1  burst in progress
- done  out  1  one-cycle pulse after final burst step

## Operation
- Modes: 000 HOLD; 001 SHL (q<<1, LSB=serial_in_l); 010 SHR (q>>1, MSB=serial_in_r); 011 LOAD (q=parallel_in); 100 ROTL; 101 ROTR; 110 ASHR (MSB replicated); 111 CLEAR (q=0).
- "Step modes" = SHL, SHR, ROTL, ROTR, ASHR.
- FSM states IDLE, BUSY.
- IDLE, start=0 or count=0 or non-step mode: apply mode once per edge (single-step behaviour); no busy, no done.
- IDLE, start=1, step mode, count≥1: that edge performs step 1, latches mode as burst_op, remaining=count−1. If count=1: stay IDLE, done=1 next cycle. Else → BUSY.
- BUSY: each edge performs one burst_op step, remaining−1; on the edge where remaining reaches 0 → IDLE, done=1 for the following cycle.
- During BUSY: mode, parallel_in, start, count ignored; serial_in_l/serial_in_r sampled live at each step.
- count > WIDTH legal: shifts saturate to fill value, rotates wrap modulo WIDTH naturally.

## Timing
- Reset values: parallel_out=0, busy=0, done=0, state IDLE, remaining=0.
- reset overrides everything; reset during BUSY aborts burst, no done pulse.
- Single-step latency: result visible one edge after mode applied.
- Burst of N accepted at edge k: steps at edges k..k+N−1; busy high in cycles after edges k..k+N−2 (never for N=1); done high exactly one cycle after edge k+N−1; new start accepted in that done cycle.
- done and busy never high together.

## Structure
- Package usr_pkg: mode enum (3-bit, codes above), FSM state enum.
- Sub-module usr_step: combinational one-step function (q, op, serial_in_l, serial_in_r → next q), shared by single-step and burst paths.
- Top holds register, FSM, remaining counter, done flop.

## Test plan (WIDTH=8, CNT_W=4)
- Reset 2 cycles with mode=LOAD, parallel_in=8'hA5 → parallel_out=0, busy=0, done=0; release, one LOAD edge → 8'hA5.
- From 8'hA5 single steps (reload each): SHL serial_in_l=1 → 8'h4B; SHR serial_in_r=0 → 8'h52; ASHR → 8'hD2; ROTL → 8'h4B; ROTR → 8'hD2; CLEAR → 8'h00; HOLD → unchanged.
- Load 8'h81, start ROTL count=3 → busy high 2 cycles, done 1 cycle, parallel_out=8'h0C; during burst drive mode=LOAD, parallel_in=8'hFF, start=1 → ignored.
- start SHL count=1 from 8'h01, serial_in_l=0 → 8'h02, busy never high, done next cycle; start with count=0 mode SHL → one step, no done.
- Load 8'hFF, start SHR count=8 serial_in_r=0, reset after 3rd edge → parallel_out=0, busy=0, no done pulse ever.
- Load 8'hFF, start SHL count=12 serial_in_l=0 → 8'h00 after 12 edges, busy 11 cycles, done once; back-to-back start in done cycle accepted.

Source files
------------

// File: rtl/usr_pkg.sv
// Shared types for the universal shift register.
// Mode codes 000-011 match the legacy 4-mode register.
package usr_pkg;

  typedef enum logic [2:0] {
    M_HOLD  = 3'b000,
    M_SHL   = 3'b001,
    M_SHR   = 3'b010,
    M_LOAD  = 3'b011,
    M_ROTL  = 3'b100,
    M_ROTR  = 3'b101,
    M_ASHR  = 3'b110,
    M_CLEAR = 3'b111
  } mode_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_e;

  function automatic logic is_step(mode_e m);
    return (m == M_SHL) || (m == M_SHR) ||
           (m == M_ROTL) || (m == M_ROTR) ||
           (m == M_ASHR);
  endfunction

endpackage

// File: rtl/usr_step.sv
// One-step next-state function for the shift register.
// Shared by the single-step and burst paths.
module usr_step
  import usr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] q,
  input  mode_e            op,
  input  logic [WIDTH-1:0] parallel_in,
  input  logic             serial_in_l,
  input  logic             serial_in_r,
  output logic [WIDTH-1:0] q_next
);

  always_comb begin
    q_next = q;
    unique case (1'b1)
      (op == M_SHL):   q_next = {q[WIDTH-2:0], serial_in_l};
      (op == M_SHR):   q_next = {serial_in_r, q[WIDTH-1:1]};
      (op == M_LOAD):  q_next = parallel_in;
      (op == M_ROTL):  q_next = {q[WIDTH-2:0], q[WIDTH-1]};
      (op == M_ROTR):  q_next = {q[0], q[WIDTH-1:1]};
      (op == M_ASHR):  q_next = {q[WIDTH-1], q[WIDTH-1:1]};
      (op == M_CLEAR): q_next = '0;
      default:         q_next = q;
    endcase
  end

endmodule

// File: rtl/univ_shift_reg_p.sv
// Parametrised universal shift register with burst engine.
// Register, burst FSM, remaining-step counter and done flop.
module univ_shift_reg_p
  import usr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] parallel_in,
  input  logic             serial_in_l,
  input  logic             serial_in_r,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] parallel_out,
  output logic             serial_out_msb,
  output logic             serial_out_lsb,
  output logic             busy,
  output logic             done
);

  state_e           state;
  mode_e            burst_op;
  mode_e            mode_in;
  mode_e            op_sel;
  logic [CNT_W-1:0] remaining;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_next;
  logic             accept;

  assign mode_in = mode_e'(mode);
  assign op_sel  = (state == S_BUSY) ? burst_op : mode_in;
  assign accept  = (state == S_IDLE) && start &&
                   is_step(mode_in) && (count != '0);

  usr_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .q           (q),
    .op          (op_sel),
    .parallel_in (parallel_in),
    .serial_in_l (serial_in_l),
    .serial_in_r (serial_in_r),
    .q_next      (q_next)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      q         <= '0;
      state     <= S_IDLE;
      burst_op  <= M_HOLD;
      remaining <= '0;
      done      <= 1'b0;
    end else begin
      q    <= q_next;
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            burst_op  <= mode_in;
            remaining <= count - CNT_W'(1);
            if (count == CNT_W'(1))
              done  <= 1'b1;
            else
              state <= S_BUSY;
          end
        end
        S_BUSY: begin
          remaining <= remaining - CNT_W'(1);
          if (remaining == CNT_W'(1)) begin
            state <= S_IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign parallel_out   = q;
  assign serial_out_msb = q[WIDTH-1];
  assign serial_out_lsb = q[0];
  assign busy           = (state == S_BUSY);

endmodule

// File: tb/tb_univ_shift_reg_p.sv
// Self-checking bench for univ_shift_reg_p.
// Behavioural model, directed cases and random stimulus.
module tb_univ_shift_reg_p;

  localparam int W  = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [2:0]    mode;
  logic [W-1:0]  parallel_in;
  logic          serial_in_l;
  logic          serial_in_r;
  logic          start;
  logic [CW-1:0] count;
  logic [W-1:0]  parallel_out;
  logic          serial_out_msb;
  logic          serial_out_lsb;
  logic          busy;
  logic          done;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] mq;
  int           left;
  logic [2:0]   mop;
  bit           mdone;

  univ_shift_reg_p #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk            (clk),
    .reset          (reset),
    .mode           (mode),
    .parallel_in    (parallel_in),
    .serial_in_l    (serial_in_l),
    .serial_in_r    (serial_in_r),
    .start          (start),
    .count          (count),
    .parallel_out   (parallel_out),
    .serial_out_msb (serial_out_msb),
    .serial_out_lsb (serial_out_lsb),
    .busy           (busy),
    .done           (done)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] f(
    logic [W-1:0] q, logic [2:0] op,
    logic [W-1:0] pi, logic sl, logic sr);
    logic [2*W-1:0] dbl;
    dbl = {q, q};
    case (op)
      3'd1: return (q << 1) | W'(sl);
      3'd2: return (q >> 1) | (W'(sr) << (W-1));
      3'd3: return pi;
      3'd4: return dbl[2*W-2 -: W];
      3'd5: return dbl[W -: W];
      3'd6: return W'($signed(q) >>> 1);
      3'd7: return '0;
      default: return q;
    endcase
  endfunction

  function automatic bit stepm(logic [2:0] m);
    return m inside {3'd1, 3'd2, 3'd4, 3'd5, 3'd6};
  endfunction

  task automatic model_edge();
    if (reset) begin
      mq = '0; left = 0; mdone = 0;
    end else if (left > 0) begin
      mq = f(mq, mop, parallel_in, serial_in_l, serial_in_r);
      left--;
      mdone = (left == 0);
    end else begin
      mdone = 0;
      mq = f(mq, mode, parallel_in, serial_in_l, serial_in_r);
      if (start && stepm(mode) && count != 0) begin
        mop   = mode;
        left  = int'(count) - 1;
        mdone = (count == 1);
      end
    end
  endtask

  task automatic chk(string nm, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    chk("q", int'(parallel_out), int'(mq));
    chk("busy", int'(busy), int'(left > 0));
    chk("done", int'(done), int'(mdone));
    chk("msb", int'(serial_out_msb), int'(mq[W-1]));
    chk("lsb", int'(serial_out_lsb), int'(mq[0]));
    if (busy && done) chk("busy_done_excl", 1, 0);
  endtask

  task automatic load(logic [W-1:0] v);
    mode = 3'd3; parallel_in = v; start = 0;
    cyc();
  endtask

  typedef struct {
    logic [2:0] m;
    logic       sl;
    logic       sr;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[7] = '{
    '{3'd1, 1'b1, 1'b0, 8'h4B},
    '{3'd2, 1'b0, 1'b0, 8'h52},
    '{3'd6, 1'b0, 1'b0, 8'hD2},
    '{3'd4, 1'b0, 1'b0, 8'h4B},
    '{3'd5, 1'b0, 1'b0, 8'hD2},
    '{3'd7, 1'b0, 1'b0, 8'h00},
    '{3'd0, 1'b0, 1'b0, 8'hA5}
  };

  initial begin
    int bc, dc, ec;
    logic [W-1:0] qd;
    mq = '0; left = 0; mop = 0; mdone = 0;
    reset = 1; mode = 3'd3; parallel_in = 8'hA5;
    serial_in_l = 0; serial_in_r = 0; start = 0; count = 0;
    cyc(); cyc();
    chk("rst_q", int'(parallel_out), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    reset = 0;
    cyc();
    chk("load_a5", int'(parallel_out), 8'hA5);

    foreach (tbl[i]) begin
      load(8'hA5);
      mode = tbl[i].m;
      serial_in_l = tbl[i].sl;
      serial_in_r = tbl[i].sr;
      cyc();
      chk($sformatf("single_%0d", i), int'(parallel_out), int'(tbl[i].exp));
    end

    load(8'h81);
    mode = 3'd4; start = 1; count = 3;
    cyc();
    bc = int'(busy); dc = 0; qd = '0;
    mode = 3'd3; parallel_in = 8'hFF; start = 1;
    for (int i = 0; i < 2; i++) begin
      cyc();
      bc += int'(busy);
      if (done) begin dc++; qd = parallel_out; end
    end
    chk("rotl_busy_cycles", bc, 2);
    chk("rotl_done_cycles", dc, 1);
    chk("rotl_result", int'(qd), 8'h0C);
    mode = 3'd0; start = 0;
    cyc();

    load(8'h01);
    mode = 3'd1; serial_in_l = 0; start = 1; count = 1;
    cyc();
    chk("c1_q", int'(parallel_out), 8'h02);
    chk("c1_busy", int'(busy), 0);
    chk("c1_done", int'(done), 1);
    count = 0;
    cyc();
    chk("c0_q", int'(parallel_out), 8'h04);
    chk("c0_done", int'(done), 0);
    chk("c0_busy", int'(busy), 0);

    load(8'hFF);
    mode = 3'd2; serial_in_r = 0; start = 1; count = 8;
    cyc();
    start = 0; mode = 3'd0;
    cyc(); cyc();
    reset = 1;
    cyc();
    chk("abort_q", int'(parallel_out), 0);
    chk("abort_busy", int'(busy), 0);
    reset = 0; dc = 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      dc += int'(done);
    end
    chk("abort_no_done", dc, 0);

    load(8'hFF);
    mode = 3'd1; serial_in_l = 0; start = 1; count = 12;
    cyc();
    start = 0; mode = 3'd0;
    bc = int'(busy); ec = 1;
    while (!done && ec < 20) begin
      cyc();
      ec++;
      bc += int'(busy);
    end
    chk("c12_done_seen", int'(done), 1);
    chk("c12_edges", ec, 12);
    chk("c12_busy", bc, 11);
    chk("c12_q", int'(parallel_out), 0);
    mode = 3'd1; serial_in_l = 1; start = 1; count = 2;
    cyc();
    chk("b2b_busy", int'(busy), 1);
    start = 0; mode = 3'd0;
    cyc();
    chk("b2b_done", int'(done), 1);
    chk("b2b_q", int'(parallel_out), 8'h03);

    for (int i = 0; i < 400; i++) begin
      reset       = ($urandom_range(0, 59) == 0);
      mode        = 3'($urandom_range(0, 7));
      parallel_in = W'($urandom);
      serial_in_l = 1'($urandom);
      serial_in_r = 1'($urandom);
      start       = ($urandom_range(0, 2) == 0);
      count       = CW'($urandom);
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
